mem_responder: RTL and testbench

Memory-side responder for the LC-3 datapath's fixed-latency memory strobes. It accepts the control unit's active-high Mem_OE/Mem_WE, which are held for exactly four cycles per access, and performs the matching access. That access goes either to the external asynchronous SRAM or to the memory-mapped I/O word (switches in, hex display out). It sits between the datapath's MAR/MDR and the board SRAM pins.

---
 rtl/mem_responder_if.sv | 38 +++
 rtl/mem_responder.sv | 118 +++++++++++
 tb/tb_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Bundle of the LC-3 memory strobes, the CPU-side data paths and the board SRAM pins.
// The slave modport is the responder's view; the master modport is the initiator/board view.
interface mem_responder_if #(
    parameter int SRAM_AW = 20
);
    logic               Mem_OE;
    logic               Mem_WE;
    logic [15:0]        MAR;
    logic [15:0]        MDR_Out;
    logic [15:0]        Switches;
    logic [15:0]        Data_to_CPU;
    logic               Data_Valid;
    logic               Busy;
    logic [15:0]        HEX_Data;
    logic [SRAM_AW-1:0] SRAM_ADDR;
    logic [15:0]        SRAM_DQ_In;
    logic [15:0]        SRAM_DQ_Out;
    logic               SRAM_DQ_En;
    logic               SRAM_CE_N;
    logic               SRAM_OE_N;
    logic               SRAM_WE_N;
    logic               SRAM_UB_N;
    logic               SRAM_LB_N;

    modport slave (
        input  Mem_OE, Mem_WE, MAR, MDR_Out, Switches, SRAM_DQ_In,
        output Data_to_CPU, Data_Valid, Busy, HEX_Data, SRAM_ADDR,
               SRAM_DQ_Out, SRAM_DQ_En, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
               SRAM_UB_N, SRAM_LB_N
    );

    modport master (
        output Mem_OE, Mem_WE, MAR, MDR_Out, Switches, SRAM_DQ_In,
        input  Data_to_CPU, Data_Valid, Busy, HEX_Data, SRAM_ADDR,
               SRAM_DQ_Out, SRAM_DQ_En, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
               SRAM_UB_N, SRAM_LB_N
    );
endinterface

// File: rtl/mem_responder.sv
// Responder for the LC-3 four-cycle Mem_OE/Mem_WE strobes: drives the async SRAM or the
// memory-mapped switch/hex I/O word. All SRAM controls decode from state so reset clears them at once.
module mem_responder #(
    parameter logic [15:0] IO_ADDR = 16'hFFFF,
    parameter int          SRAM_AW = 20
) (
    input  logic            Clk,
    input  logic            Reset,
    mem_responder_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE, RD1, RD2, RD3, RD4, WR1, WR2, WR3, WR4, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q,  addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] hex_q,   hex_d;
    logic        is_io_q, is_io_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hex_q   <= '0;
            is_io_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
            is_io_q <= is_io_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        is_io_d = is_io_q;
        case (state_q)
            IDLE: begin
                // A write strobe takes priority over a simultaneous read strobe.
                if (bus.Mem_WE) begin
                    state_d = WR1;
                    addr_d  = bus.MAR;
                    wdata_d = bus.MDR_Out;
                    is_io_d = (bus.MAR == IO_ADDR);
                end else if (bus.Mem_OE) begin
                    state_d = RD1;
                    addr_d  = bus.MAR;
                    is_io_d = (bus.MAR == IO_ADDR);
                end
            end
            RD1: state_d = bus.Mem_OE ? RD2 : IDLE;
            RD2: state_d = bus.Mem_OE ? RD3 : IDLE;
            RD3: begin
                if (bus.Mem_OE) begin
                    state_d = RD4;
                    rdata_d = is_io_q ? bus.Switches : bus.SRAM_DQ_In;
                end else begin
                    state_d = IDLE;
                end
            end
            RD4: state_d = DONE;
            WR1: begin
                if (bus.Mem_WE) begin
                    state_d = WR2;
                    if (is_io_q) begin
                        hex_d = wdata_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR2: state_d = bus.Mem_WE ? WR3 : IDLE;
            WR3: state_d = bus.Mem_WE ? WR4 : IDLE;
            WR4: state_d = DONE;
            // Wait for the strobe to fall so a long strobe cannot start a second access.
            DONE: if (!bus.Mem_OE && !bus.Mem_WE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic sram_rd, sram_wr, sram_we;

    always_comb begin
        sram_rd = 1'b0;
        sram_wr = 1'b0;
        sram_we = 1'b0;
        if (!is_io_q) begin
            sram_rd = (state_q == RD1) || (state_q == RD2) || (state_q == RD3);
            sram_wr = (state_q == WR1) || (state_q == WR2) || (state_q == WR3) || (state_q == WR4);
            sram_we = (state_q == WR2) || (state_q == WR3);
        end
    end

    assign bus.Data_to_CPU = rdata_q;
    assign bus.Data_Valid  = (state_q == RD4);
    assign bus.Busy        = (state_q != IDLE);
    assign bus.HEX_Data    = hex_q;
    assign bus.SRAM_ADDR   = SRAM_AW'(addr_q);
    assign bus.SRAM_DQ_Out = wdata_q;
    assign bus.SRAM_DQ_En  = sram_wr;
    assign bus.SRAM_CE_N   = !(sram_rd || sram_wr);
    assign bus.SRAM_OE_N   = !sram_rd;
    assign bus.SRAM_WE_N   = !sram_we;
    assign bus.SRAM_UB_N   = !(sram_rd || sram_wr);
    assign bus.SRAM_LB_N   = !(sram_rd || sram_wr);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: behavioural SRAM, per-cycle strobe checks and a read-data scoreboard.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_responder_if bus ();

    mem_responder dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural async SRAM; address 0x12 powers up holding 16'hBEEF.
    logic [15:0]  sram_mem [0:255];
    logic [255:0] sram_seen = '0;
    logic [7:0]   sram_a;
    assign sram_a = bus.SRAM_ADDR[7:0];

    always @(posedge clk) begin
        if (!bus.SRAM_CE_N && !bus.SRAM_WE_N && bus.SRAM_DQ_En) begin
            sram_mem[sram_a]  <= bus.SRAM_DQ_Out;
            sram_seen[sram_a] <= 1'b1;
        end
    end

    assign bus.SRAM_DQ_In = (bus.SRAM_CE_N || bus.SRAM_OE_N) ? 16'h0000 :
                            sram_seen[sram_a] ? sram_mem[sram_a] :
                            (sram_a == 8'h12) ? 16'hBEEF : 16'h0000;

    logic [15:0] exp_q [$];

    always @(negedge clk) begin
        if (!rst && bus.Data_Valid) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb_unexpected_valid got=%h expected=no read pending", bus.Data_to_CPU);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus.Data_to_CPU !== e) begin
                    errors = errors + 1;
                    $display("FAIL sb_read_data got=%h expected=%h", bus.Data_to_CPU, e);
                end
            end
        end
    end

    logic [7:0]  v_oe_n, v_we_n, v_ce_n, v_en, v_dv, v_busy;
    logic [15:0] obs_rd  [8];
    logic [15:0] obs_hex [8];
    logic [19:0] obs_addr[8];

    task automatic run_access(input logic oe, input logic we, input logic [15:0] addr,
                              input logic [15:0] data, input int n);
        v_oe_n = '0; v_we_n = '0; v_ce_n = '0; v_en = '0; v_dv = '0; v_busy = '0;
        @(negedge clk);
        bus.Mem_OE = oe; bus.Mem_WE = we; bus.MAR = addr; bus.MDR_Out = data;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            v_oe_n[k] = bus.SRAM_OE_N;
            v_we_n[k] = bus.SRAM_WE_N;
            v_ce_n[k] = bus.SRAM_CE_N;
            v_en[k]   = bus.SRAM_DQ_En;
            v_dv[k]   = bus.Data_Valid;
            v_busy[k] = bus.Busy;
            obs_rd[k]   = bus.Data_to_CPU;
            obs_hex[k]  = bus.HEX_Data;
            obs_addr[k] = bus.SRAM_ADDR;
        end
        @(negedge clk);
        bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] n_all;
        #1;
        n_all = {bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_UB_N, bus.SRAM_LB_N};
        checks = checks + 1;
        if ({bus.Data_to_CPU, bus.Data_Valid, bus.Busy, bus.HEX_Data} !== 34'h0) begin
            errors = errors + 1;
            $display("FAIL reset_cpu_side got=%h/%b/%b/%h expected=0000/0/0/0000",
                     bus.Data_to_CPU, bus.Data_Valid, bus.Busy, bus.HEX_Data);
        end
        checks = checks + 1;
        if ({bus.SRAM_ADDR, bus.SRAM_DQ_Out, bus.SRAM_DQ_En} !== 37'h0) begin
            errors = errors + 1;
            $display("FAIL reset_sram_bus got=%h/%h/%b expected=00000/0000/0",
                     bus.SRAM_ADDR, bus.SRAM_DQ_Out, bus.SRAM_DQ_En);
        end
        checks = checks + 1;
        if (n_all !== 5'b11111) begin
            errors = errors + 1;
            $display("FAIL reset_sram_n got=%b expected=11111", n_all);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks = checks + 1;
        if (bus.Busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL idle_busy got=%b expected=0", bus.Busy);
        end
    endtask

    task automatic test_sram_read();
        exp_q.push_back(16'hBEEF);
        run_access(1'b1, 1'b0, 16'h0012, 16'h0000, 5);
        checks = checks + 1;
        if (v_oe_n[4:0] !== 5'b11000) begin
            errors = errors + 1;
            $display("FAIL rd_oe_n got=%b expected=11000", v_oe_n[4:0]);
        end
        checks = checks + 1;
        if (v_dv[4:0] !== 5'b01000 || obs_rd[3] !== 16'hBEEF) begin
            errors = errors + 1;
            $display("FAIL rd_valid got=%b/%h expected=01000/beef", v_dv[4:0], obs_rd[3]);
        end
        checks = checks + 1;
        if (obs_addr[0] !== 20'h00012) begin
            errors = errors + 1;
            $display("FAIL rd_addr got=%h expected=00012", obs_addr[0]);
        end
    endtask

    task automatic test_sram_write();
        run_access(1'b0, 1'b1, 16'h0040, 16'h1234, 5);
        checks = checks + 1;
        if (v_we_n[4:0] !== 5'b11001) begin
            errors = errors + 1;
            $display("FAIL wr_we_n got=%b expected=11001", v_we_n[4:0]);
        end
        checks = checks + 1;
        if (v_en[4:0] !== 5'b01111 || v_ce_n[4:0] !== 5'b10000) begin
            errors = errors + 1;
            $display("FAIL wr_en_ce got=%b/%b expected=01111/10000", v_en[4:0], v_ce_n[4:0]);
        end
        exp_q.push_back(16'h1234);
        run_access(1'b1, 1'b0, 16'h0040, 16'h0000, 5);
        checks = checks + 1;
        if (obs_rd[3] !== 16'h1234) begin
            errors = errors + 1;
            $display("FAIL wr_readback got=%h expected=1234", obs_rd[3]);
        end
    endtask

    task automatic test_io();
        run_access(1'b0, 1'b1, 16'hFFFF, 16'h00A5, 5);
        checks = checks + 1;
        if (obs_hex[0] !== 16'h0000 || obs_hex[1] !== 16'h00A5) begin
            errors = errors + 1;
            $display("FAIL io_hex got=%h,%h expected=0000,00a5", obs_hex[0], obs_hex[1]);
        end
        checks = checks + 1;
        if ({v_ce_n[4:0], v_we_n[4:0], v_oe_n[4:0], v_en[4:0]} !== 20'hFFFE0) begin
            errors = errors + 1;
            $display("FAIL io_wr_no_strobe got=%b/%b/%b/%b expected=11111/11111/11111/00000",
                     v_ce_n[4:0], v_we_n[4:0], v_oe_n[4:0], v_en[4:0]);
        end
        bus.Switches = 16'h0F0F;
        exp_q.push_back(16'h0F0F);
        run_access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 5);
        checks = checks + 1;
        if (obs_rd[3] !== 16'h0F0F || v_ce_n[4:0] !== 5'b11111) begin
            errors = errors + 1;
            $display("FAIL io_rd got=%h/%b expected=0f0f/11111", obs_rd[3], v_ce_n[4:0]);
        end
    endtask

    task automatic test_simultaneous();
        run_access(1'b1, 1'b1, 16'h0050, 16'h5A5A, 5);
        checks = checks + 1;
        if (v_dv[4:0] !== 5'b00000 || v_we_n[4:0] !== 5'b11001) begin
            errors = errors + 1;
            $display("FAIL both_strobes got=dv %b we_n %b expected=dv 00000 we_n 11001",
                     v_dv[4:0], v_we_n[4:0]);
        end
        exp_q.push_back(16'h5A5A);
        run_access(1'b1, 1'b0, 16'h0050, 16'h0000, 5);
    endtask

    task automatic test_long_strobe();
        exp_q.push_back(16'hBEEF);
        run_access(1'b1, 1'b0, 16'h0012, 16'h0000, 7);
        checks = checks + 1;
        if (v_busy[6:0] !== 7'h7F || v_dv[6:0] !== 7'b0001000) begin
            errors = errors + 1;
            $display("FAIL long_strobe got=busy %b dv %b expected=busy 1111111 dv 0001000",
                     v_busy[6:0], v_dv[6:0]);
        end
        @(posedge clk); #1;
        checks = checks + 1;
        if (bus.Busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL long_release got=%b expected=0", bus.Busy);
        end
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 1'b1, 16'h0060, 16'hCAFE, 5);
        exp_q.push_back(16'hCAFE);
        run_access(1'b1, 1'b0, 16'h0060, 16'h0000, 5);
        checks = checks + 1;
        if (v_dv[4:0] !== 5'b01000 || obs_rd[3] !== 16'hCAFE) begin
            errors = errors + 1;
            $display("FAIL b2b got=%b/%h expected=01000/cafe", v_dv[4:0], obs_rd[3]);
        end
    endtask

    task automatic test_abort();
        run_access(1'b1, 1'b0, 16'h0012, 16'h0000, 2);
        @(posedge clk); #1;
        checks = checks + 1;
        if (bus.Busy !== 1'b0 || bus.SRAM_OE_N !== 1'b1 || bus.SRAM_CE_N !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL abort_idle got=busy %b oe_n %b ce_n %b expected=0 1 1",
                     bus.Busy, bus.SRAM_OE_N, bus.SRAM_CE_N);
        end
        checks = checks + 1;
        if (bus.Data_to_CPU !== 16'hCAFE) begin
            errors = errors + 1;
            $display("FAIL abort_data got=%h expected=cafe", bus.Data_to_CPU);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        bus.Mem_OE = 1'b1; bus.MAR = 16'h0012;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks = checks + 1;
        if (bus.SRAM_OE_N !== 1'b1 || bus.SRAM_CE_N !== 1'b1 || bus.Busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL rst_mid_strobes got=oe_n %b ce_n %b busy %b expected=1 1 0",
                     bus.SRAM_OE_N, bus.SRAM_CE_N, bus.Busy);
        end
        checks = checks + 1;
        if (bus.Data_to_CPU !== 16'h0000 || bus.HEX_Data !== 16'h0000) begin
            errors = errors + 1;
            $display("FAIL rst_mid_data got=%h/%h expected=0000/0000", bus.Data_to_CPU, bus.HEX_Data);
        end
        bus.Mem_OE = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b0; bus.MAR = '0; bus.MDR_Out = '0; bus.Switches = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_sram_read();
        test_sram_write();
        test_io();
        test_simultaneous();
        test_long_strobe();
        test_back_to_back();
        test_abort();
        test_reset_mid_read();
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL sb_pending got=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
